// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// datapath mux codes and the packed control vector.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_LUI      = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

  localparam logic [2:0] EXT_IMM_I = 3'd0;
  localparam logic [2:0] EXT_IMM_S = 3'd1;
  localparam logic [2:0] EXT_IMM_B = 3'd2;
  localparam logic [2:0] EXT_IMM_U = 3'd3;
  localparam logic [2:0] EXT_IMM_J = 3'd4;

  localparam logic [2:0] FROM_ALU    = 3'd0;
  localparam logic [2:0] FROM_ALUOUT = 3'd1;
  localparam logic [2:0] FROM_MEM    = 3'd2;
  localparam logic [2:0] FROM_PC     = 3'd3;
  localparam logic [2:0] FROM_IMM    = 3'd4;

  localparam logic [2:0] ALUOP_LOAD_STORE = 3'd0;
  localparam logic [2:0] ALUOP_BRANCH     = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE      = 3'd2;
  localparam logic [2:0] ALUOP_ITYPE      = 3'd3;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [3:0] FUNCT3_BNE = 4'd1;

  typedef struct packed {
    logic       pc_we;
    logic       oldpc_we;
    logic       ir_we;
    logic       adr_src;
    logic       mem_re;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] sel_ext;
    logic [2:0] result_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outputs.sv
// Combinational control vector: current state plus opcode/funct3 and the
// mem_ready / Zero qualifiers mapped onto every datapath enable and mux.
module mc_ctrl_outputs
  import multicycle_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic is_bne;

  assign is_bne = SUPPORT_BNE && (funct3 == FUNCT3_BNE[2:0]);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_re    = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALUOP_LOAD_STORE;
        ctrl.result_src = FROM_ALU;
        if (mem_ready) begin
          ctrl.ir_we    = 1'b1;
          ctrl.oldpc_we = 1'b1;
          ctrl.pc_we    = 1'b1;
        end
      end
      ST_DECODE: begin
        // Branch target is computed speculatively so BRANCH can load it from ALUOut.
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.sel_ext   = EXT_IMM_B;
        ctrl.alu_op    = ALUOP_LOAD_STORE;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.sel_ext   = (opcode == OPCODE_STORE) ? EXT_IMM_S : EXT_IMM_I;
        ctrl.alu_op    = ALUOP_LOAD_STORE;
      end
      ST_MEMREAD: begin
        ctrl.mem_re  = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.rf_we      = 1'b1;
        ctrl.result_src = FROM_MEM;
      end
      ST_MEMWRITE: begin
        ctrl.dmem_we = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.sel_ext   = EXT_IMM_I;
        ctrl.alu_op    = ALUOP_ITYPE;
      end
      ST_ALUWB: begin
        ctrl.rf_we      = 1'b1;
        ctrl.result_src = FROM_ALU;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALUOP_BRANCH;
        ctrl.result_src = FROM_ALUOUT;
        ctrl.pc_we      = is_bne ? ~zero : zero;
      end
      ST_JAL: begin
        ctrl.sel_ext    = EXT_IMM_J;
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALUOP_LOAD_STORE;
        ctrl.pc_we      = 1'b1;
        ctrl.rf_we      = 1'b1;
        ctrl.result_src = FROM_PC;
      end
      ST_LUI: begin
        ctrl.sel_ext    = EXT_IMM_U;
        ctrl.rf_we      = 1'b1;
        ctrl.result_src = FROM_IMM;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with mem_ready handshake, wait watchdog,
// optional BNE and illegal-opcode trap.
//
//  state       | meaning
//  FETCH       | read instruction at PC, PC+4 on mem_ready
//  DECODE      | branch target into ALUOut, dispatch on opcode
//  MEMADR      | rs1 + imm address for load/store
//  MEMREAD     | data read, wait for mem_ready
//  MEMWB       | load data into rd
//  MEMWRITE    | data write, held until mem_ready
//  EXEC_R/I    | ALU op on rs1 with rs2 / imm
//  ALUWB       | ALU result into rd
//  BRANCH      | compare, conditionally load target
//  JAL         | jump, link PC+4 into rd
//  LUI         | upper immediate into rd
//  TRAP        | terminal until reset (illegal opcode or bus error)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit SUPPORT_BNE     = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int WAIT_TIMEOUT    = 16,
  parameter int TO_W            = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        oldpc_we,
  output logic        ir_we,
  output logic        adr_src,
  output logic        mem_re,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  sel_ext,
  output logic [2:0]  ResultSrc,
  output logic [2:0]  ALUOp,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state_o
);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wd;
  logic            waiting;
  logic            timeout;
  logic            illegal_hit;
  logic [6:0]      opcode;
  ctrl_t           ctrl_raw, ctrl;
  logic            unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^{inst[31:15], inst[11:7]};

  assign waiting = is_wait_state(state) && !mem_ready;
  // A ready on the final allowed cycle wins over the watchdog.
  assign timeout = waiting && (wd == TO_W'(WAIT_TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    illegal_hit = 1'b0;
    case (state)
      ST_FETCH:    if (mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPCODE_LOAD,
          OPCODE_STORE:  state_nxt = ST_MEMADR;
          OPCODE_RTYPE:  state_nxt = ST_EXEC_R;
          OPCODE_ITYPE:  state_nxt = ST_EXEC_I;
          OPCODE_BRANCH: state_nxt = ST_BRANCH;
          OPCODE_JAL:    state_nxt = ST_JAL;
          OPCODE_LUI:    state_nxt = ST_LUI;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_nxt   = ST_TRAP;
              illegal_hit = 1'b1;
            end else begin
              state_nxt = ST_FETCH;
            end
          end
        endcase
      end
      ST_MEMADR:   state_nxt = (opcode == OPCODE_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  if (mem_ready) state_nxt = ST_MEMWB;
      ST_MEMWRITE: if (mem_ready) state_nxt = ST_FETCH;
      ST_EXEC_R,
      ST_EXEC_I:   state_nxt = ST_ALUWB;
      ST_MEMWB,
      ST_ALUWB,
      ST_BRANCH,
      ST_JAL,
      ST_LUI:      state_nxt = ST_FETCH;
      ST_TRAP:     state_nxt = ST_TRAP;
      default:     state_nxt = ST_FETCH;
    endcase
    if (timeout) state_nxt = ST_TRAP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      wd      <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wd    <= waiting ? wd + TO_W'(1) : '0;
      if (timeout)     bus_err <= 1'b1;
      if (illegal_hit) illegal <= 1'b1;
    end
  end

  mc_ctrl_outputs #(
    .SUPPORT_BNE(SUPPORT_BNE)
  ) u_outputs (
    .state    (state),
    .opcode   (opcode),
    .funct3   (inst[14:12]),
    .zero     (Zero),
    .mem_ready(mem_ready),
    .ctrl     (ctrl_raw)
  );

  // Held in reset the FETCH request must not reach the bus, so gate combinationally.
  always_comb begin
    ctrl = ctrl_raw;
    if (!rst_n) ctrl = '0;
  end

  assign pc_we     = ctrl.pc_we;
  assign oldpc_we  = ctrl.oldpc_we;
  assign ir_we     = ctrl.ir_we;
  assign adr_src   = ctrl.adr_src;
  assign mem_re    = ctrl.mem_re;
  assign dmem_we   = ctrl.dmem_we;
  assign rf_we     = ctrl.rf_we;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign sel_ext   = ctrl.sel_ext;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign state_o   = state;

endmodule
